// File: rtl/cycloneii_pll_cntr_cfg.sv
// ---------------------------------------------------------------------------
// cycloneii_pll_cntr_cfg
//   Reconfiguration sequencer for the PLL post-scale/feedback counter bank.
//   A host fills shadow modulus/initial registers through a req/ack write
//   port. A reconfig command serialises the whole bank onto the counter scan
//   chain and then issues one update strobe, so all counters reload together.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   wr_en        in   host write request, held until wr_ack
//   wr_idx       in   target counter index
//   wr_modulus   in   new modulus
//   wr_initial   in   new initial value
//   wr_ack       out  one-cycle write acknowledge
//   cfg_error    out  one-cycle, with wr_ack, when the write was rejected
//   reconfig     in   start reconfiguration (level, sampled in IDLE)
//   busy         out  high from reconfig acceptance until sequence complete
//   scan_en      out  scan chain shift enable
//   scan_data    out  serial chain data, valid while scan_en=1
//   cntr_update  out  one-cycle strobe: counters load the scanned values
// ---------------------------------------------------------------------------
module cycloneii_pll_cntr_cfg #(
   parameter int unsigned NUM_CNTR = 6,
   parameter int unsigned MOD_W    = 9,
   parameter int unsigned IDX_W    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [MOD_W-1:0] wr_modulus,
   input  logic [MOD_W-1:0] wr_initial,
   output logic             wr_ack,
   output logic             cfg_error,
   input  logic             reconfig,
   output logic             busy,
   output logic             scan_en,
   output logic             scan_data,
   output logic             cntr_update
);

   localparam int unsigned TOTAL = NUM_CNTR * 2 * MOD_W;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);
   localparam int unsigned SEG_W = 2 * MOD_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_SHIFT  = 2'd2;
   localparam logic [1:0] S_UPDATE = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [TOTAL-1:0] r_shift;
   logic [TOTAL-1:0] w_bank;
   logic [MOD_W-1:0] r_mod  [NUM_CNTR];
   logic [MOD_W-1:0] r_init [NUM_CNTR];
   logic             r_busy;
   logic             r_ack;
   logic             r_err;
   logic             r_scan_en;
   logic             r_update;
   logic             w_wr_take;
   logic             w_wr_bad;

   // A write is taken only while idle and not in its own ack cycle, so a
   // request held until ack is never committed twice.
   assign w_wr_take = wr_en && !r_busy && !r_ack;
   assign w_wr_bad  = (32'(wr_idx) >= NUM_CNTR) || (wr_modulus == '0) ||
                      (wr_initial == '0);

   // Chain image: counter NUM_CNTR-1 in the MSBs, each segment {initial,modulus}.
   always_comb begin
      w_bank = '0;
      for (int i = 0; i < NUM_CNTR; i++) begin
         w_bank[i*SEG_W +: SEG_W] = {r_init[i], r_mod[i]};
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (reconfig) w_next = S_LOAD;
         S_LOAD:   w_next = S_SHIFT;
         S_SHIFT:  if (r_cnt == CNT_W'(TOTAL - 1)) w_next = S_UPDATE;
         S_UPDATE: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Registered outputs decoded from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_scan_en <= 1'b0;
         r_update  <= 1'b0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_busy    <= (w_next != S_IDLE);
         r_scan_en <= (w_next == S_SHIFT);
         r_update  <= (w_next == S_UPDATE);
         r_ack     <= w_wr_take;
         r_err     <= w_wr_take && w_wr_bad;
      end
   end

   // Shift register and bit counter; snapshot taken at the end of LOAD
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (r_state == S_LOAD) begin
         r_shift <= w_bank;
         r_cnt   <= '0;
      end else if (r_state == S_SHIFT) begin
         r_shift <= {r_shift[TOTAL-2:0], 1'b0};
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

   // Shadow bank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNTR; i++) begin
            r_mod[i]  <= MOD_W'(1);
            r_init[i] <= MOD_W'(1);
         end
      end else if (w_wr_take && !w_wr_bad) begin
         for (int i = 0; i < NUM_CNTR; i++) begin
            if (32'(wr_idx) == i) begin
               r_mod[i]  <= wr_modulus;
               r_init[i] <= wr_initial;
            end
         end
      end
   end

   assign wr_ack      = r_ack;
   assign cfg_error   = r_err;
   assign busy        = r_busy;
   assign scan_en     = r_scan_en;
   assign scan_data   = r_shift[TOTAL-1];
   assign cntr_update = r_update;

endmodule

// File: tb/tb_cycloneii_pll_cntr_cfg.sv
// ---------------------------------------------------------------------------
// tb_cycloneii_pll_cntr_cfg
//   Bench for the PLL counter reconfiguration sequencer. A small instance
//   (2 counters x 4 bits) is exercised with directed and random writes and
//   compared with a shadow-bank model; a default-sized instance checks the
//   sequence length for the full bank.
// ---------------------------------------------------------------------------
module tb_cycloneii_pll_cntr_cfg;

   localparam int unsigned N  = 2;
   localparam int unsigned MW = 4;
   localparam int unsigned IW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [MW-1:0] wr_modulus;
   logic [MW-1:0] wr_initial;
   logic          wr_ack;
   logic          cfg_error;
   logic          reconfig;
   logic          busy;
   logic          scan_en;
   logic          scan_data;
   logic          cntr_update;

   logic          wr_en6;
   logic [2:0]    wr_idx6;
   logic [8:0]    wr_modulus6;
   logic [8:0]    wr_initial6;
   logic          wr_ack6;
   logic          cfg_error6;
   logic          reconfig6;
   logic          busy6;
   logic          scan_en6;
   logic          scan_data6;
   logic          cntr_update6;

   int total = 0;
   int bad   = 0;
   int m_mod  [N];
   int m_init [N];

   always #5 clk = ~clk;

   cycloneii_pll_cntr_cfg #(.NUM_CNTR(N), .MOD_W(MW), .IDX_W(IW)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_modulus(wr_modulus), .wr_initial(wr_initial), .wr_ack(wr_ack),
      .cfg_error(cfg_error), .reconfig(reconfig), .busy(busy),
      .scan_en(scan_en), .scan_data(scan_data), .cntr_update(cntr_update)
   );

   cycloneii_pll_cntr_cfg dut6 (
      .clk(clk), .reset(reset), .wr_en(wr_en6), .wr_idx(wr_idx6),
      .wr_modulus(wr_modulus6), .wr_initial(wr_initial6), .wr_ack(wr_ack6),
      .cfg_error(cfg_error6), .reconfig(reconfig6), .busy(busy6),
      .scan_en(scan_en6), .scan_data(scan_data6), .cntr_update(cntr_update6)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected chain image: highest counter first, {initial,modulus} each.
   function automatic logic [15:0] model_stream();
      int s = 0;
      for (int c = N - 1; c >= 0; c--) s = s * 256 + m_init[c] * 16 + m_mod[c];
      return 16'(s);
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < N; c++) begin
         m_mod[c]  = 1;
         m_init[c] = 1;
      end
   endfunction

   task automatic do_write(input int idx, input int md, input int ini, output int wait_cyc);
      int got;
      int exp_err;
      wr_idx     = IW'(idx);
      wr_modulus = MW'(md);
      wr_initial = MW'(ini);
      wr_en      = 1'b1;
      wait_cyc   = 0;
      got        = 0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         wait_cyc++;
         if (wr_ack) begin
            got = 1;
            break;
         end
      end
      exp_err = (idx >= N || md == 0 || ini == 0) ? 1 : 0;
      chk("wr_ack_seen", 32'(got), 32'd1);
      chk("cfg_error", 32'(cfg_error), 32'(exp_err));
      wr_en = 1'b0;
      @(posedge clk); #1;
      chk("wr_ack_one_cycle", 32'(wr_ack), 32'd0);
      chk("cfg_error_one_cycle", 32'(cfg_error), 32'd0);
      if (exp_err == 0) begin
         m_mod[idx]  = md;
         m_init[idx] = ini;
      end
   endtask

   // Runs one sequence; at busy cycle 'hook' a write request and a reconfig
   // pulse are raised to test that nothing disturbs the transfer in flight.
   task automatic run_seq(input int hook, output logic [15:0] bits, output int nbits,
                          output int bcyc, output int nupd, output int acks);
      bits  = '0;
      nbits = 0;
      bcyc  = 0;
      nupd  = 0;
      acks  = 0;
      reconfig = 1'b1;
      @(posedge clk); #1;
      reconfig = 1'b0;
      wr_en    = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (!busy) break;
         if (k == hook) begin
            wr_en    = 1'b1;
            reconfig = 1'b1;
         end
         if (k == hook + 1) reconfig = 1'b0;
         if (scan_en) begin
            bits = {bits[14:0], scan_data};
            nbits++;
         end
         nupd += int'(cntr_update);
         acks += int'(wr_ack);
         bcyc++;
         @(posedge clk); #1;
      end
      chk("idle_scan_en", 32'(scan_en), 32'd0);
      chk("idle_update", 32'(cntr_update), 32'd0);
   endtask

   task automatic check_seq(input string tag, input int hook, input logic [15:0] exp_bits);
      logic [15:0] bits;
      int nbits, bcyc, nupd, acks;
      run_seq(hook, bits, nbits, bcyc, nupd, acks);
      chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
      chk({tag, "_nbits"}, 32'(nbits), 32'd16);
      chk({tag, "_busy"}, 32'(bcyc), 32'd18);
      chk({tag, "_update"}, 32'(nupd), 32'd1);
   endtask

   initial begin
      logic [15:0] bits;
      int nbits, bcyc, nupd, acks, wcyc, n6, ones6;

      reset = 1'b1;
      wr_en = 1'b0; wr_idx = '0; wr_modulus = '0; wr_initial = '0; reconfig = 1'b0;
      wr_en6 = 1'b0; wr_idx6 = '0; wr_modulus6 = '0; wr_initial6 = '0; reconfig6 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outputs", {26'd0, wr_ack, cfg_error, busy, scan_en, scan_data, cntr_update}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Default bank
      check_seq("t1", -1, 16'h1111);

      // Directed writes
      do_write(1, 5, 3, wcyc);
      chk("t2_wait", 32'(wcyc), 32'd1);
      do_write(0, 12, 2, wcyc);
      check_seq("t2", -1, 16'h3528 + 16'h0004);
      chk("t2_model", 32'(model_stream()), 32'h352C);

      // Rejected writes leave the bank alone
      do_write(2, 7, 7, wcyc);
      do_write(1, 0, 4, wcyc);
      do_write(0, 6, 0, wcyc);
      check_seq("t3", -1, 16'h352C);

      // Write and reconfig raised mid-shift
      wr_idx = IW'(1); wr_modulus = MW'(10); wr_initial = MW'(6);
      run_seq(6, bits, nbits, bcyc, nupd, acks);
      chk("t4_bits", 32'(bits), 32'h352C);
      chk("t4_busy", 32'(bcyc), 32'd18);
      chk("t4_no_ack_busy", 32'(acks), 32'd0);
      do_write(1, 10, 6, wcyc);
      chk("t4_ack_after_idle", 32'(wcyc), 32'd1);
      chk("t4_not_queued", 32'(busy), 32'd0);
      check_seq("t4b", -1, model_stream());
      chk("t4b_model", 32'(model_stream()), 32'h6A2C);

      // Reset partway through the shift
      reconfig = 1'b1;
      @(posedge clk); #1;
      reconfig = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      chk("t5_in_shift", 32'(scan_en), 32'd1);
      reset = 1'b1;
      #1;
      chk("t5_async_scan_en", 32'(scan_en), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("t5_no_update", 32'(cntr_update), 32'd0);
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check_seq("t5", -1, 16'h1111);

      // Write and reconfig on the same edge
      wr_idx = '0; wr_modulus = MW'(9); wr_initial = MW'(4); wr_en = 1'b1;
      run_seq(-1, bits, nbits, bcyc, nupd, acks);
      m_mod[0] = 9;
      m_init[0] = 4;
      chk("t6_tail", 32'(bits[3:0]), 32'd9);
      chk("t6_bits", 32'(bits), 32'(model_stream()));
      chk("t6_ack", 32'(acks), 32'd1);
      chk("t6_busy", 32'(bcyc), 32'd18);

      // Random writes against the model
      for (int r = 0; r < 6; r++) begin
         for (int w = 0; w < 3; w++) begin
            do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), wcyc);
         end
         check_seq("rnd", -1, model_stream());
      end

      // Full-size default bank: 6 x 2 x 9 = 108 bits, busy for 110 cycles
      reconfig6 = 1'b1;
      @(posedge clk); #1;
      reconfig6 = 1'b0;
      bcyc = 0; n6 = 0; ones6 = 0; nupd = 0;
      for (int k = 0; k < 300; k++) begin
         if (!busy6) break;
         if (scan_en6) begin
            n6++;
            ones6 += int'(scan_data6);
         end
         nupd += int'(cntr_update6);
         bcyc++;
         @(posedge clk); #1;
      end
      chk("t6_full_busy", 32'(bcyc), 32'd110);
      chk("t6_full_bits", 32'(n6), 32'd108);
      chk("t6_full_ones", 32'(ones6), 32'd12);
      chk("t6_full_update", 32'(nupd), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
